// File: rtl/macarray_param_if.sv
// Control/status and memory-port bundle for macarray_param.
// master = the engine, slave = the host plus the I/W/O memories.
interface macarray_param_if #(
  parameter int DW   = 8,
  parameter int MAXD = 8
);
  localparam int WW   = MAXD * DW;
  localparam int DIMW = $clog2(MAXD) + 1;
  localparam int AW   = $clog2(MAXD);
  localparam int OAW  = $clog2(2 * MAXD);

  logic              START;
  logic [3*DIMW-1:0] MNT;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic              EN_I;
  logic [AW-1:0]     ADDR_I;
  logic [WW-1:0]     RDATA_I;
  logic              EN_W;
  logic [AW-1:0]     ADDR_W;
  logic [WW-1:0]     RDATA_W;
  logic              EN_O;
  logic              RW_O;
  logic [OAW-1:0]    ADDR_O;
  logic [WW-1:0]     WDATA_O;

  modport master (
    input  START, MNT, RDATA_I, RDATA_W,
    output BUSY, DONE, ERR, EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, WDATA_O
  );

  modport slave (
    output START, MNT, RDATA_I, RDATA_W,
    input  BUSY, DONE, ERR, EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, WDATA_O
  );
endinterface

// File: rtl/macarray_param.sv
// Runtime-sized matrix multiply O = I * W, one output element per cycle.
// Define MACARRAY_SAT_EN to saturate results to the signed 2*DW range instead of wrapping.
//
// state | meaning
// IDLE  | waiting for START; dimensions checked on acceptance
// RD_I  | read I row t, clear row buffer and result slots
// RD_W  | read W column m, one per cycle, M cycles
// DRAIN | last MAC result lands in its slot
// WR0   | write word 2t (slots 0..MAXD/2-1)
// WR1   | write word 2t+1 (slots MAXD/2..MAXD-1), then next row or finish
// FIN   | one-cycle DONE pulse
module macarray_param #(
  parameter int DW   = 8,
  parameter int MAXD = 8
) (
  input  logic CLK,
  input  logic RSTN,
  macarray_param_if.master bus
);
  localparam int WW   = MAXD * DW;
  localparam int DIMW = $clog2(MAXD) + 1;
  localparam int AW   = $clog2(MAXD);
  localparam int OAW  = $clog2(2 * MAXD);
  localparam int SW   = 2 * DW;
  localparam int ACCW = 2 * DW + $clog2(MAXD);

  typedef enum logic [2:0] {IDLE, RD_I, RD_W, DRAIN, WR0, WR1, FIN} state_t;

  state_t            state;
  logic [DIMW-1:0]   n_q, m_q, t_q, m_cnt;
  logic [AW-1:0]     t_cnt;
  logic [DIMW-1:0]   mnt_n, mnt_m, mnt_t;
  logic              dim_bad;

  logic [WW-1:0]     row_q, row_m;
  logic [2*WW-1:0]   slot_q, slot_nxt;
  logic              i_vld_q, w_vld_q;
  logic [AW-1:0]     w_idx_q;

  logic signed [DW-1:0]   a_k, b_k;
  logic signed [SW-1:0]   a_x, b_x, p_k;
  logic signed [ACCW-1:0] acc;
  logic [SW-1:0]          res;

  assign mnt_n = bus.MNT[3*DIMW-1 -: DIMW];
  assign mnt_m = bus.MNT[2*DIMW-1 -: DIMW];
  assign mnt_t = bus.MNT[DIMW-1:0];
  assign dim_bad = (mnt_n == '0) || (mnt_n > DIMW'(MAXD)) ||
                   (mnt_m == '0) || (mnt_m > DIMW'(MAXD)) ||
                   (mnt_t == '0) || (mnt_t > DIMW'(MAXD));

  always_comb begin
    row_m = '0;
    for (int k = 0; k < MAXD; k++) begin
      if (k < int'(n_q)) row_m[WW-1-k*DW -: DW] = bus.RDATA_I[WW-1-k*DW -: DW];
    end
  end

  // Full-precision signed dot product of the row buffer with the W word in flight
  always_comb begin
    acc = '0;
    a_k = '0;
    b_k = '0;
    a_x = '0;
    b_x = '0;
    p_k = '0;
    for (int k = 0; k < MAXD; k++) begin
      if (k < int'(n_q)) begin
        a_k = row_q[WW-1-k*DW -: DW];
        b_k = bus.RDATA_W[WW-1-k*DW -: DW];
        a_x = {{DW{a_k[DW-1]}}, a_k};
        b_x = {{DW{b_k[DW-1]}}, b_k};
        p_k = a_x * b_x;
        acc = acc + {{(ACCW-SW){p_k[SW-1]}}, p_k};
      end
    end
  end

`ifdef MACARRAY_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-SW+1){1'b1}}, {(SW-1){1'b0}}};
  always_comb begin
    if (acc > SAT_MAX)      res = {1'b0, {(SW-1){1'b1}}};
    else if (acc < SAT_MIN) res = {1'b1, {(SW-1){1'b0}}};
    else                    res = acc[SW-1:0];
  end
`else
  always_comb res = acc[SW-1:0];
`endif

  always_comb begin
    slot_nxt = slot_q;
    if (w_vld_q) slot_nxt[2*WW-1-int'(w_idx_q)*SW -: SW] = res;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      row_q   <= '0;
      slot_q  <= '0;
      i_vld_q <= 1'b0;
      w_vld_q <= 1'b0;
      w_idx_q <= '0;
    end else begin
      i_vld_q <= bus.EN_I;
      w_vld_q <= bus.EN_W;
      w_idx_q <= bus.ADDR_W;
      if (state == RD_I) begin
        row_q  <= '0;
        slot_q <= '0;
      end else begin
        if (i_vld_q) row_q <= row_m;
        slot_q <= slot_nxt;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      n_q         <= '0;
      m_q         <= '0;
      t_q         <= '0;
      m_cnt       <= '0;
      t_cnt       <= '0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
      bus.ERR     <= 1'b0;
      bus.EN_I    <= 1'b0;
      bus.ADDR_I  <= '0;
      bus.EN_W    <= 1'b0;
      bus.ADDR_W  <= '0;
      bus.EN_O    <= 1'b0;
      bus.RW_O    <= 1'b0;
      bus.ADDR_O  <= '0;
      bus.WDATA_O <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            n_q <= mnt_n;
            m_q <= mnt_m;
            t_q <= mnt_t;
            if (dim_bad) begin
              bus.ERR  <= 1'b1;
              bus.DONE <= 1'b1;
              state    <= FIN;
            end else begin
              bus.ERR    <= 1'b0;
              bus.BUSY   <= 1'b1;
              bus.EN_I   <= 1'b1;
              bus.ADDR_I <= '0;
              t_cnt      <= '0;
              state      <= RD_I;
            end
          end
        end
        RD_I: begin
          bus.EN_I   <= 1'b0;
          bus.EN_W   <= 1'b1;
          bus.ADDR_W <= '0;
          m_cnt      <= '0;
          state      <= RD_W;
        end
        RD_W: begin
          if (m_cnt == m_q - DIMW'(1)) begin
            bus.EN_W <= 1'b0;
            state    <= DRAIN;
          end else begin
            m_cnt      <= m_cnt + DIMW'(1);
            bus.ADDR_W <= bus.ADDR_W + AW'(1);
          end
        end
        DRAIN: begin
          // slot_nxt already includes the result being captured this cycle
          bus.EN_O    <= 1'b1;
          bus.RW_O    <= 1'b1;
          bus.ADDR_O  <= OAW'({t_cnt, 1'b0});
          bus.WDATA_O <= slot_nxt[2*WW-1 -: WW];
          state       <= WR0;
        end
        WR0: begin
          bus.ADDR_O  <= OAW'({t_cnt, 1'b1});
          bus.WDATA_O <= slot_q[WW-1:0];
          state       <= WR1;
        end
        WR1: begin
          bus.EN_O <= 1'b0;
          bus.RW_O <= 1'b0;
          if ({1'b0, t_cnt} == t_q - DIMW'(1)) begin
            bus.BUSY <= 1'b0;
            bus.DONE <= 1'b1;
            state    <= FIN;
          end else begin
            t_cnt      <= t_cnt + AW'(1);
            bus.ADDR_I <= t_cnt + AW'(1);
            bus.EN_I   <= 1'b1;
            state      <= RD_I;
          end
        end
        FIN: begin
          bus.DONE <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_macarray_param.sv
// Bench for macarray_param: directed cases plus random matrices against an
// arithmetic matrix-product model; memories modelled with one-cycle read latency.
module tb_macarray_param;
  localparam int DW   = 8;
  localparam int MAXD = 8;
  localparam int WW   = MAXD * DW;
  localparam int DIMW = $clog2(MAXD) + 1;
  localparam int SW   = 2 * DW;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;

  macarray_param_if #(.DW(DW), .MAXD(MAXD)) bus ();

  macarray_param #(.DW(DW), .MAXD(MAXD)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.master)
  );

  always #5 CLK = ~CLK;

  logic [WW-1:0] imem [MAXD];
  logic [WW-1:0] wmem [MAXD];
  logic [WW-1:0] omem [2*MAXD];
  logic [WW-1:0] rdi = '0, rdw = '0;
  int wr_cnt = 0, ei_cnt = 0, ew_cnt = 0;
  int checks = 0, errors = 0;

  assign bus.RDATA_I = rdi;
  assign bus.RDATA_W = rdw;

  always @(posedge CLK) begin
    if (bus.EN_I) rdi <= imem[bus.ADDR_I];
    if (bus.EN_W) rdw <= wmem[bus.ADDR_W];
    if (bus.EN_I) ei_cnt <= ei_cnt + 1;
    if (bus.EN_W) ew_cnt <= ew_cnt + 1;
    if (bus.EN_O && bus.RW_O) begin
      omem[bus.ADDR_O] <= bus.WDATA_O;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*DIMW-1:0] mnt_of(input int n, input int m, input int t);
    return {n[DIMW-1:0], m[DIMW-1:0], t[DIMW-1:0]};
  endfunction

  // O[r][mm] = sum_k I[r][k] * W[mm][k], reduced to SW bits, packed two words per row
  function automatic logic [WW-1:0] exp_word(input int r, input int half, input int n, input int m);
    logic [WW-1:0] w;
    logic [31:0] u;
    logic [SW-1:0] v;
    int s, mm;
    w = '0;
    for (int j = 0; j < MAXD/2; j++) begin
      mm = half * (MAXD/2) + j;
      s = 0;
      if (mm < m)
        for (int k = 0; k < n; k++)
          s += int'($signed(imem[r][WW-1-k*DW -: DW])) * int'($signed(wmem[mm][WW-1-k*DW -: DW]));
      u = s;
      v = u[SW-1:0];
`ifdef MACARRAY_SAT_EN
      if (s > (1 << (SW-1)) - 1) v = {1'b0, {(SW-1){1'b1}}};
      else if (s < -(1 << (SW-1))) v = {1'b1, {(SW-1){1'b0}}};
`endif
      w[WW-1-j*SW -: SW] = v;
    end
    return w;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < MAXD; i++) begin
      imem[i] = '0;
      wmem[i] = '0;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MAXD; i++)
      for (int k = 0; k < MAXD; k++) begin
        imem[i][WW-1-k*DW -: DW] = DW'($urandom);
        wmem[i][WW-1-k*DW -: DW] = DW'($urandom);
      end
  endtask

  task automatic run_op(input int n, input int m, input int t, input bit poke);
    int b_wr, b_ei, b_ew, done_cyc, busy_cyc;
    bit bad, err1, err_done;
    bad = (n == 0 || n > MAXD || m == 0 || m > MAXD || t == 0 || t > MAXD);
    @(negedge CLK);
    b_wr = wr_cnt; b_ei = ei_cnt; b_ew = ew_cnt;
    bus.MNT = mnt_of(n, m, t);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    done_cyc = -1; busy_cyc = 0; err1 = 1'b0; err_done = 1'b0;
    for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
      if (c > 1) @(negedge CLK);
      if (poke && c == 3) bus.START = 1'b1;
      if (poke && c == 4) bus.START = 1'b0;
      if (bus.BUSY) busy_cyc++;
      if (c == 1) err1 = bus.ERR;
      if (bus.DONE) begin
        done_cyc = c;
        err_done = bus.ERR;
      end
    end
    chk("done_cycle", done_cyc, bad ? 1 : t * (m + 4) + 1);
    chk("err_cycle1", err1, bad);
    chk("err_at_done", err_done, bad);
    chk("busy_cycles", busy_cyc, bad ? 0 : t * (m + 4));
    // START held during FIN must not launch a new operation
    bus.START = poke;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("idle_after_fin", {bus.BUSY, bus.DONE, bus.EN_I}, 3'b000);
    @(negedge CLK);
    chk("no_restart", bus.BUSY, 1'b0);
    chk("en_i_count", ei_cnt - b_ei, bad ? 0 : t);
    chk("en_w_count", ew_cnt - b_ew, bad ? 0 : t * m);
    chk("write_count", wr_cnt - b_wr, bad ? 0 : 2 * t);
    if (!bad)
      for (int r = 0; r < t; r++) begin
        chk($sformatf("word%0d", 2*r), omem[2*r], exp_word(r, 0, n, m));
        chk($sformatf("word%0d", 2*r+1), omem[2*r+1], exp_word(r, 1, n, m));
      end
  endtask

  initial begin
    logic [SW-1:0] s127;
    int b_wr, b_ei;
    bus.START = 1'b0;
    bus.MNT = '0;
    clear_mem();
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {bus.BUSY, bus.DONE, bus.ERR, bus.EN_I, bus.ADDR_I, bus.EN_W, bus.ADDR_W,
                          bus.EN_O, bus.RW_O, bus.ADDR_O, bus.WDATA_O}, '0);
    RSTN = 1'b1;

    // 2x2 example
    clear_mem();
    imem[0] = {8'd1, 8'd2, 48'd0};
    imem[1] = {8'd3, 8'd4, 48'd0};
    wmem[0] = {8'd5, 8'd7, 48'd0};
    wmem[1] = {8'd6, 8'd8, 48'd0};
    run_op(2, 2, 2, 1'b0);
    chk("t1_addr0", omem[0], 64'h0013_0016_0000_0000);
    chk("t1_addr1", omem[1], 64'h0);
    chk("t1_addr2", omem[2], 64'h002B_0032_0000_0000);
    chk("t1_addr3", omem[3], 64'h0);

    // full size, largest positive operands
    for (int i = 0; i < MAXD; i++) begin
      imem[i] = {MAXD{8'd127}};
      wmem[i] = {MAXD{8'd127}};
    end
    run_op(8, 8, 8, 1'b0);
`ifdef MACARRAY_SAT_EN
    s127 = 16'h7FFF;
`else
    s127 = 16'hF808;
`endif
    chk("t2_addr0", omem[0], {4{s127}});
    chk("t2_addr15", omem[15], {4{s127}});

    // negative result
    clear_mem();
    imem[0] = {8'hFF, 56'd0};
    wmem[0] = {8'd3, 56'd0};
    run_op(1, 1, 1, 1'b0);
    chk("t3_addr0", omem[0], 64'hFFFD_0000_0000_0000);
    chk("t3_addr1", omem[1], 64'h0);

    // lanes beyond N carry garbage that must be masked
    clear_mem();
    imem[0] = {8'd1, 8'd1, 8'd1, {5{8'h55}}};
    wmem[0] = {8'd1, 8'd1, 8'd1, {5{8'h7F}}};
    wmem[1] = {8'd1, 8'd1, 8'd1, {5{8'h7F}}};
    run_op(3, 2, 1, 1'b0);
    chk("t4_addr0", omem[0], 64'h0003_0003_0000_0000);

    // dimension errors, ERR held, cleared by the next good START
    run_op(9, 2, 2, 1'b0);
    repeat (3) @(negedge CLK);
    chk("err_held", bus.ERR, 1'b1);
    run_op(2, 0, 2, 1'b0);
    fill_rand();
    run_op(2, 2, 1, 1'b0);
    chk("err_cleared", bus.ERR, 1'b0);

    // START during RD_W ignored
    fill_rand();
    run_op(2, 3, 2, 1'b1);

    // reset in WR0 of row 1 (cycle 11 for M=2)
    fill_rand();
    @(negedge CLK);
    b_wr = wr_cnt;
    bus.MNT = mnt_of(2, 2, 2);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("rst_in_wr0", {bus.EN_O, bus.ADDR_O}, {1'b1, 4'd2});
    RSTN = 1'b0;
    @(negedge CLK);
    chk("rst_outputs", {bus.BUSY, bus.DONE, bus.ERR, bus.EN_I, bus.ADDR_I, bus.EN_W, bus.ADDR_W,
                        bus.EN_O, bus.RW_O, bus.ADDR_O, bus.WDATA_O}, '0);
    chk("rst_writes", wr_cnt - b_wr, 2);
    chk("rst_word0", omem[0], exp_word(0, 0, 2, 2));
    b_ei = ei_cnt;
    RSTN = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rst_idle", {bus.BUSY, bus.EN_I, bus.EN_W, bus.EN_O}, 4'b0000);
    chk("rst_no_reads", ei_cnt - b_ei, 0);
    chk("rst_no_more_writes", wr_cnt - b_wr, 2);

    // random matrices and dimensions
    for (int it = 0; it < 8; it++) begin
      fill_rand();
      run_op($urandom_range(1, MAXD), $urandom_range(1, MAXD), $urandom_range(1, MAXD),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
